// File: rtl/br_issue_queue.sv
// br_issue_queue: in-order issue queue in front of the branch unit.
// Buffers dispatched branch uops, snoops write-back, issues the head entry.
module br_issue_queue #(
    parameter int DEPTH  = 8,
    parameter int PREG_W = 7,
    parameter int DATA_W = 32,
    parameter int OP_W   = 8
) (
    input  logic              Clk,
    input  logic              Rest,
    input  logic              BiqFlash,
    input  logic              DispValid,
    output logic              DispReady,
    input  logic [DATA_W-1:0] DispInstPc,
    input  logic [OP_W-1:0]   DispMicOperate,
    input  logic [25:0]       DispImmDate,
    input  logic              DispMode,
    input  logic [DATA_W-1:0] DispReDirDate,
    input  logic              DispSrc1Able,
    input  logic [PREG_W-1:0] DispSrc1Addr,
    input  logic              DispSrc1Ready,
    input  logic [DATA_W-1:0] DispSrc1Date,
    input  logic              DispSrc2Able,
    input  logic [PREG_W-1:0] DispSrc2Addr,
    input  logic              DispSrc2Ready,
    input  logic [DATA_W-1:0] DispSrc2Date,
    input  logic              DispRdAble,
    input  logic [PREG_W-1:0] DispRdAddr,
    input  logic [5:0]        DispROBPtr,
    input  logic              WbAlu1Able,
    input  logic [PREG_W-1:0] WbAlu1Addr,
    input  logic [DATA_W-1:0] WbAlu1Date,
    input  logic              WbAlu2Able,
    input  logic [PREG_W-1:0] WbAlu2Addr,
    input  logic [DATA_W-1:0] WbAlu2Date,
    input  logic              WbMulAble,
    input  logic [PREG_W-1:0] WbMulAddr,
    input  logic [DATA_W-1:0] WbMulDate,
    input  logic              WbCsrAble,
    input  logic [PREG_W-1:0] WbCsrAddr,
    input  logic [DATA_W-1:0] WbCsrDate,
    input  logic              WbBruAble,
    input  logic [PREG_W-1:0] WbBruAddr,
    input  logic [DATA_W-1:0] WbBruDate,
    input  logic              BruReqInst,
    output logic              IqBruValid,
    output logic [DATA_W-1:0] IqBruInstPc,
    output logic [OP_W-1:0]   IqBruMicOperate,
    output logic              IqBruSrc1Able,
    output logic [PREG_W-1:0] IqBruSrc1Addr,
    output logic [DATA_W-1:0] IqBruSrc1Date,
    output logic              IqBruSrc2Able,
    output logic [PREG_W-1:0] IqBruSrc2Addr,
    output logic [DATA_W-1:0] IqBruSrc2Date,
    output logic [25:0]       IqBruImmDate,
    output logic              IqBruRdAble,
    output logic [PREG_W-1:0] IqBruRdAddr,
    output logic              IqBruMode,
    output logic [DATA_W-1:0] IqBruReDirDate,
    output logic [5:0]        IqBruROBPtr
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int NWB = 5;

    typedef struct packed {
        logic              hit;
        logic [DATA_W-1:0] data;
    } wake_t;

    // Index 0 has the highest capture priority.
    logic [NWB-1:0]             w_wb_able;
    logic [NWB-1:0][PREG_W-1:0] w_wb_addr;
    logic [NWB-1:0][DATA_W-1:0] w_wb_data;

    assign w_wb_able = {WbBruAble, WbCsrAble, WbMulAble,
                        WbAlu2Able, WbAlu1Able};
    assign w_wb_addr = {WbBruAddr, WbCsrAddr, WbMulAddr,
                        WbAlu2Addr, WbAlu1Addr};
    assign w_wb_data = {WbBruDate, WbCsrDate, WbMulDate,
                        WbAlu2Date, WbAlu1Date};

    function automatic wake_t f_wake(
        input logic [PREG_W-1:0]             tag,
        input logic [NWB-1:0]                able,
        input logic [NWB-1:0][PREG_W-1:0]    addr,
        input logic [NWB-1:0][DATA_W-1:0]    data
    );
        wake_t res;
        res = '0;
        for (int k = NWB - 1; k >= 0; k--) begin
            if (able[k] && (addr[k] == tag) && (tag != '0)) begin
                res.hit  = 1'b1;
                res.data = data[k];
            end
        end
        return res;
    endfunction

    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [DEPTH-1:0] r_valid;

    logic [DATA_W-1:0] r_pc     [DEPTH];
    logic [OP_W-1:0]   r_op     [DEPTH];
    logic [25:0]       r_imm    [DEPTH];
    logic              r_mode   [DEPTH];
    logic [DATA_W-1:0] r_redir  [DEPTH];
    logic              r_s1_able[DEPTH];
    logic [PREG_W-1:0] r_s1_addr[DEPTH];
    logic              r_s1_rdy [DEPTH];
    logic [DATA_W-1:0] r_s1_data[DEPTH];
    logic              r_s2_able[DEPTH];
    logic [PREG_W-1:0] r_s2_addr[DEPTH];
    logic              r_s2_rdy [DEPTH];
    logic [DATA_W-1:0] r_s2_data[DEPTH];
    logic              r_rd_able[DEPTH];
    logic [PREG_W-1:0] r_rd_addr[DEPTH];
    logic [5:0]        r_rob    [DEPTH];

    logic              w_head_rdy;
    logic              w_issue;
    logic              w_enq;
    wake_t             w_d1;
    wake_t             w_d2;
    logic              w_n1_rdy;
    logic              w_n2_rdy;
    logic [DATA_W-1:0] w_n1_data;
    logic [DATA_W-1:0] w_n2_data;
    wake_t             w_e1 [DEPTH];
    wake_t             w_e2 [DEPTH];

    // Space is judged on registered occupancy only.
    assign DispReady = (r_count < CW'(DEPTH));

    assign w_head_rdy = (!r_s1_able[r_head] || r_s1_rdy[r_head]) &&
                        (!r_s2_able[r_head] || r_s2_rdy[r_head]);
    assign w_issue = (r_count != '0) && w_head_rdy &&
                     BruReqInst && !BiqFlash;
    assign w_enq = DispValid && DispReady && !BiqFlash;

    // Tag match for the incoming uop and for every stored entry.
    always_comb begin
        w_d1 = f_wake(DispSrc1Addr, w_wb_able, w_wb_addr, w_wb_data);
        w_d2 = f_wake(DispSrc2Addr, w_wb_able, w_wb_addr, w_wb_data);
        for (int i = 0; i < DEPTH; i++) begin
            w_e1[i] = f_wake(r_s1_addr[i], w_wb_able,
                             w_wb_addr, w_wb_data);
            w_e2[i] = f_wake(r_s2_addr[i], w_wb_able,
                             w_wb_addr, w_wb_data);
        end
    end

    // A dispatched source waiting on a tag broadcast this cycle lands ready.
    always_comb begin
        w_n1_rdy  = !DispSrc1Able || DispSrc1Ready || w_d1.hit;
        w_n2_rdy  = !DispSrc2Able || DispSrc2Ready || w_d2.hit;
        w_n1_data = DispSrc1Date;
        w_n2_data = DispSrc2Date;
        if (DispSrc1Able && !DispSrc1Ready && w_d1.hit) begin
            w_n1_data = w_d1.data;
        end
        if (DispSrc2Able && !DispSrc2Ready && w_d2.hit) begin
            w_n2_data = w_d2.data;
        end
    end

    // Queue pointers, occupancy and entry valid bits.
    always_ff @(posedge Clk) begin
        if (Rest || BiqFlash) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_enq) begin
                r_tail          <= r_tail + AW'(1);
                r_valid[r_tail] <= 1'b1;
            end
            if (w_issue) begin
                r_head          <= r_head + AW'(1);
                r_valid[r_head] <= 1'b0;
            end
            r_count <= r_count + CW'(w_enq) - CW'(w_issue);
        end
    end

    // Capture broadcasts into waiting entries; write the new uop at tail.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && r_s1_able[i] && !r_s1_rdy[i] &&
                w_e1[i].hit) begin
                r_s1_rdy[i]  <= 1'b1;
                r_s1_data[i] <= w_e1[i].data;
            end
            if (r_valid[i] && r_s2_able[i] && !r_s2_rdy[i] &&
                w_e2[i].hit) begin
                r_s2_rdy[i]  <= 1'b1;
                r_s2_data[i] <= w_e2[i].data;
            end
        end
        if (w_enq) begin
            r_pc[r_tail]      <= DispInstPc;
            r_op[r_tail]      <= DispMicOperate;
            r_imm[r_tail]     <= DispImmDate;
            r_mode[r_tail]    <= DispMode;
            r_redir[r_tail]   <= DispReDirDate;
            r_s1_able[r_tail] <= DispSrc1Able;
            r_s1_addr[r_tail] <= DispSrc1Addr;
            r_s1_rdy[r_tail]  <= w_n1_rdy;
            r_s1_data[r_tail] <= w_n1_data;
            r_s2_able[r_tail] <= DispSrc2Able;
            r_s2_addr[r_tail] <= DispSrc2Addr;
            r_s2_rdy[r_tail]  <= w_n2_rdy;
            r_s2_data[r_tail] <= w_n2_data;
            r_rd_able[r_tail] <= DispRdAble;
            r_rd_addr[r_tail] <= DispRdAddr;
            r_rob[r_tail]     <= DispROBPtr;
        end
    end

    // Registered issue bundle; zero means no-op for the branch unit.
    always_ff @(posedge Clk) begin
        if (Rest || !w_issue) begin
            IqBruValid      <= 1'b0;
            IqBruInstPc     <= '0;
            IqBruMicOperate <= '0;
            IqBruSrc1Able   <= 1'b0;
            IqBruSrc1Addr   <= '0;
            IqBruSrc1Date   <= '0;
            IqBruSrc2Able   <= 1'b0;
            IqBruSrc2Addr   <= '0;
            IqBruSrc2Date   <= '0;
            IqBruImmDate    <= '0;
            IqBruRdAble     <= 1'b0;
            IqBruRdAddr     <= '0;
            IqBruMode       <= 1'b0;
            IqBruReDirDate  <= '0;
            IqBruROBPtr     <= '0;
        end else begin
            IqBruValid      <= 1'b1;
            IqBruInstPc     <= r_pc[r_head];
            IqBruMicOperate <= r_op[r_head];
            IqBruSrc1Able   <= r_s1_able[r_head];
            IqBruSrc1Addr   <= r_s1_addr[r_head];
            IqBruSrc1Date   <= r_s1_data[r_head];
            IqBruSrc2Able   <= r_s2_able[r_head];
            IqBruSrc2Addr   <= r_s2_addr[r_head];
            IqBruSrc2Date   <= r_s2_data[r_head];
            IqBruImmDate    <= r_imm[r_head];
            IqBruRdAble     <= r_rd_able[r_head];
            IqBruRdAddr     <= r_rd_addr[r_head];
            IqBruMode       <= r_mode[r_head];
            IqBruReDirDate  <= r_redir[r_head];
            IqBruROBPtr     <= r_rob[r_head];
        end
    end

endmodule

// File: tb/tb_br_issue_queue.sv
// tb_br_issue_queue: directed table, corner sequences and random traffic
// for br_issue_queue, checked against a queue-based reference model.
module tb_br_issue_queue;

    localparam int DEPTH = 8;
    localparam int NWB   = 5;

    logic        Clk = 1'b0;
    logic        Rest, BiqFlash, DispValid, DispReady;
    logic [31:0] DispInstPc, DispReDirDate;
    logic [7:0]  DispMicOperate;
    logic [25:0] DispImmDate;
    logic        DispMode;
    logic        DispSrc1Able, DispSrc1Ready, DispSrc2Able, DispSrc2Ready;
    logic [6:0]  DispSrc1Addr, DispSrc2Addr, DispRdAddr;
    logic [31:0] DispSrc1Date, DispSrc2Date;
    logic        DispRdAble;
    logic [5:0]  DispROBPtr;
    logic        wa [NWB];
    logic [6:0]  wt [NWB];
    logic [31:0] wd [NWB];
    logic        BruReqInst;
    logic        IqBruValid;
    logic [31:0] IqBruInstPc, IqBruSrc1Date, IqBruSrc2Date, IqBruReDirDate;
    logic [7:0]  IqBruMicOperate;
    logic        IqBruSrc1Able, IqBruSrc2Able, IqBruRdAble, IqBruMode;
    logic [6:0]  IqBruSrc1Addr, IqBruSrc2Addr, IqBruRdAddr;
    logic [25:0] IqBruImmDate;
    logic [5:0]  IqBruROBPtr;

    always #5 Clk = ~Clk;

    br_issue_queue dut (
        .Clk(Clk), .Rest(Rest), .BiqFlash(BiqFlash),
        .DispValid(DispValid), .DispReady(DispReady),
        .DispInstPc(DispInstPc), .DispMicOperate(DispMicOperate),
        .DispImmDate(DispImmDate), .DispMode(DispMode),
        .DispReDirDate(DispReDirDate),
        .DispSrc1Able(DispSrc1Able), .DispSrc1Addr(DispSrc1Addr),
        .DispSrc1Ready(DispSrc1Ready), .DispSrc1Date(DispSrc1Date),
        .DispSrc2Able(DispSrc2Able), .DispSrc2Addr(DispSrc2Addr),
        .DispSrc2Ready(DispSrc2Ready), .DispSrc2Date(DispSrc2Date),
        .DispRdAble(DispRdAble), .DispRdAddr(DispRdAddr),
        .DispROBPtr(DispROBPtr),
        .WbAlu1Able(wa[0]), .WbAlu1Addr(wt[0]), .WbAlu1Date(wd[0]),
        .WbAlu2Able(wa[1]), .WbAlu2Addr(wt[1]), .WbAlu2Date(wd[1]),
        .WbMulAble(wa[2]), .WbMulAddr(wt[2]), .WbMulDate(wd[2]),
        .WbCsrAble(wa[3]), .WbCsrAddr(wt[3]), .WbCsrDate(wd[3]),
        .WbBruAble(wa[4]), .WbBruAddr(wt[4]), .WbBruDate(wd[4]),
        .BruReqInst(BruReqInst),
        .IqBruValid(IqBruValid), .IqBruInstPc(IqBruInstPc),
        .IqBruMicOperate(IqBruMicOperate),
        .IqBruSrc1Able(IqBruSrc1Able), .IqBruSrc1Addr(IqBruSrc1Addr),
        .IqBruSrc1Date(IqBruSrc1Date),
        .IqBruSrc2Able(IqBruSrc2Able), .IqBruSrc2Addr(IqBruSrc2Addr),
        .IqBruSrc2Date(IqBruSrc2Date),
        .IqBruImmDate(IqBruImmDate), .IqBruRdAble(IqBruRdAble),
        .IqBruRdAddr(IqBruRdAddr), .IqBruMode(IqBruMode),
        .IqBruReDirDate(IqBruReDirDate), .IqBruROBPtr(IqBruROBPtr)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  op;
        logic [25:0] imm;
        logic        mode;
        logic [31:0] rdr;
        logic        s1a;
        logic [6:0]  s1t;
        logic        s1r;
        logic [31:0] s1d;
        logic        s2a;
        logic [6:0]  s2t;
        logic        s2r;
        logic [31:0] s2d;
        logic        rda;
        logic [6:0]  rdt;
        logic [5:0]  rob;
    } uop_t;

    typedef struct packed {
        logic rst, fl, dv, req;
        logic [7:0]  op;
        logic [5:0]  rob;
        logic        s1a, s1r;
        logic [6:0]  s1t;
        logic [31:0] s1d;
        logic        s2a, s2r;
        logic [6:0]  s2t;
        logic [31:0] s2d;
        logic [2:0]  wp0;
        logic [6:0]  wt0;
        logic [31:0] wd0;
        logic [2:0]  wp1;
        logic [6:0]  wt1;
        logic [31:0] wd1;
        logic        xrdy, xval;
        logic [7:0]  xop;
        logic [31:0] xs1, xs2;
        logic [5:0]  xrob;
    } vec_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    string phase = "init";
    uop_t  mq[$];
    logic  ev;
    uop_t  eo;
    vec_t  tbl[$];

    task automatic chk(input string nm, input logic [255:0] a,
                       input logic [255:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s/%s: got %0h want %0h", phase, nm, a, e);
        end
    endtask

    // Reference model: list of pending uops, oldest first.
    function automatic void mwake(input logic [6:0] tag, output bit hit,
                                  output logic [31:0] d);
        hit = 0;
        d   = '0;
        for (int k = 0; k < NWB; k++) begin
            if (!hit && wa[k] && tag != 0 && wt[k] == tag) begin
                hit = 1;
                d   = wd[k];
            end
        end
    endfunction

    function automatic bit ready_u(input uop_t u);
        return (!u.s1a || u.s1r) && (!u.s2a || u.s2r);
    endfunction

    function automatic uop_t cur_disp();
        uop_t u;
        u.pc = DispInstPc; u.op = DispMicOperate; u.imm = DispImmDate;
        u.mode = DispMode; u.rdr = DispReDirDate;
        u.s1a = DispSrc1Able; u.s1t = DispSrc1Addr;
        u.s1r = DispSrc1Ready; u.s1d = DispSrc1Date;
        u.s2a = DispSrc2Able; u.s2t = DispSrc2Addr;
        u.s2r = DispSrc2Ready; u.s2d = DispSrc2Date;
        u.rda = DispRdAble; u.rdt = DispRdAddr; u.rob = DispROBPtr;
        return u;
    endfunction

    function automatic uop_t wake_u(input uop_t u);
        bit h;
        logic [31:0] d;
        if (u.s1a && !u.s1r) begin
            mwake(u.s1t, h, d);
            if (h) begin u.s1r = 1; u.s1d = d; end
        end
        if (u.s2a && !u.s2r) begin
            mwake(u.s2t, h, d);
            if (h) begin u.s2r = 1; u.s2d = d; end
        end
        return u;
    endfunction

    task automatic model_step();
        bit iss, enq;
        ev = 0;
        eo = '0;
        if (Rest || BiqFlash) begin
            mq.delete();
            return;
        end
        iss = mq.size() != 0 && BruReqInst && ready_u(mq[0]);
        enq = DispValid && mq.size() < DEPTH;
        if (iss) begin
            ev = 1;
            eo = mq.pop_front();
        end
        foreach (mq[i]) mq[i] = wake_u(mq[i]);
        if (enq) mq.push_back(wake_u(cur_disp()));
    endtask

    function automatic uop_t act_bundle();
        uop_t a;
        a.pc = IqBruInstPc; a.op = IqBruMicOperate; a.imm = IqBruImmDate;
        a.mode = IqBruMode; a.rdr = IqBruReDirDate;
        a.s1a = IqBruSrc1Able; a.s1t = IqBruSrc1Addr;
        a.s1r = 0; a.s1d = IqBruSrc1Date;
        a.s2a = IqBruSrc2Able; a.s2t = IqBruSrc2Addr;
        a.s2r = 0; a.s2d = IqBruSrc2Date;
        a.rda = IqBruRdAble; a.rdt = IqBruRdAddr; a.rob = IqBruROBPtr;
        return a;
    endfunction

    task automatic tick();
        uop_t e;
        @(posedge Clk);
        model_step();
        #1;
        e = eo;
        e.s1r = 0;
        e.s2r = 0;
        chk("ready", DispReady, mq.size() < DEPTH);
        chk("valid", IqBruValid, ev);
        chk("bundle", act_bundle(), e);
    endtask

    task automatic clr_wb();
        for (int k = 0; k < NWB; k++) begin
            wa[k] = 0; wt[k] = '0; wd[k] = '0;
        end
    endtask

    task automatic set_wb(input logic [2:0] p, input logic [6:0] t,
                          input logic [31:0] d);
        if (p < 3'd5) begin
            wa[p] = 1; wt[p] = t; wd[p] = d;
        end
    endtask

    task automatic drive_disp(
        input logic [7:0] op, input logic [5:0] rob,
        input logic s1a, input logic s1r,
        input logic [6:0] s1t, input logic [31:0] s1d,
        input logic s2a, input logic s2r,
        input logic [6:0] s2t, input logic [31:0] s2d);
        DispValid = 1;
        DispMicOperate = op; DispROBPtr = rob;
        DispInstPc = 32'h1000 + {24'h0, rob, 2'b00};
        DispImmDate = {20'h0, rob}; DispMode = rob[0];
        DispReDirDate = 32'h2000 + {26'h0, rob};
        DispRdAble = 1; DispRdAddr = {1'b0, rob};
        DispSrc1Able = s1a; DispSrc1Ready = s1r;
        DispSrc1Addr = s1t; DispSrc1Date = s1d;
        DispSrc2Able = s2a; DispSrc2Ready = s2r;
        DispSrc2Addr = s2t; DispSrc2Date = s2d;
    endtask

    task automatic idle();
        Rest = 0; BiqFlash = 0; DispValid = 0;
        clr_wb();
    endtask

    task automatic do_reset();
        idle();
        Rest = 1;
        tick();
        Rest = 0;
    endtask

    task automatic add(
        input logic rst, input logic fl, input logic dv, input logic req,
        input logic [7:0] op, input logic [5:0] rob,
        input logic s1a, input logic s1r,
        input logic [6:0] s1t, input logic [31:0] s1d,
        input logic s2a, input logic s2r,
        input logic [6:0] s2t, input logic [31:0] s2d,
        input logic [2:0] wp0, input logic [6:0] wt0, input logic [31:0] wd0,
        input logic [2:0] wp1, input logic [6:0] wt1, input logic [31:0] wd1,
        input logic xrdy, input logic xval, input logic [7:0] xop,
        input logic [31:0] xs1, input logic [31:0] xs2,
        input logic [5:0] xrob);
        vec_t v;
        v = {rst, fl, dv, req, op, rob, s1a, s1r, s1t, s1d,
             s2a, s2r, s2t, s2d, wp0, wt0, wd0, wp1, wt1, wd1,
             xrdy, xval, xop, xs1, xs2, xrob};
        tbl.push_back(v);
    endtask

    task automatic drive_rand();
        DispValid = 1'($urandom_range(0, 1));
        DispInstPc = $urandom; DispReDirDate = $urandom;
        DispMicOperate = 8'($urandom_range(1, 255));
        DispImmDate = 26'($urandom); DispMode = 1'($urandom);
        DispSrc1Able = $urandom_range(0, 4) != 0;
        DispSrc1Ready = 1'($urandom_range(0, 1));
        DispSrc1Addr = ($urandom_range(0, 19) == 0) ? 7'd0
                       : 7'($urandom_range(1, 6));
        DispSrc1Date = $urandom;
        DispSrc2Able = $urandom_range(0, 4) != 0;
        DispSrc2Ready = 1'($urandom_range(0, 1));
        DispSrc2Addr = ($urandom_range(0, 19) == 0) ? 7'd0
                       : 7'($urandom_range(1, 6));
        DispSrc2Date = $urandom;
        DispRdAble = 1'($urandom); DispRdAddr = 7'($urandom);
        DispROBPtr = 6'($urandom);
        for (int k = 0; k < NWB; k++) begin
            wa[k] = $urandom_range(0, 3) == 0;
            wt[k] = 7'($urandom_range(0, 6));
            wd[k] = $urandom;
        end
        BruReqInst = $urandom_range(0, 9) < 6;
        BiqFlash = $urandom_range(0, 59) == 0;
        Rest = $urandom_range(0, 299) == 0;
    endtask

    initial begin
        vec_t v;
        idle();
        BruReqInst = 0;
        DispInstPc = 0; DispMicOperate = 0; DispImmDate = 0; DispMode = 0;
        DispReDirDate = 0; DispRdAble = 0; DispRdAddr = 0; DispROBPtr = 0;
        DispSrc1Able = 0; DispSrc1Addr = 0; DispSrc1Ready = 0;
        DispSrc1Date = 0; DispSrc2Able = 0; DispSrc2Addr = 0;
        DispSrc2Ready = 0; DispSrc2Date = 0;

        // rst fl dv req op rob | s1 a r t d | s2 a r t d | wb0 | wb1 | exp
        add(1,0,0,0, 0,0, 0,0,0,0, 0,0,0,0, 7,0,0, 7,0,0, 1,0,0,0,0,0);
        add(0,0,1,1, 8'h01,1, 1,1,0,5, 1,1,0,5, 7,0,0, 7,0,0, 1,0,0,0,0,0);
        add(0,0,0,1, 0,0, 0,0,0,0, 0,0,0,0, 7,0,0, 7,0,0, 1,1,8'h01,5,5,1);
        add(0,0,0,1, 0,0, 0,0,0,0, 0,0,0,0, 7,0,0, 7,0,0, 1,0,0,0,0,0);
        add(0,0,1,1, 8'h02,2, 1,1,0,1, 1,0,7'h12,0, 7,0,0, 7,0,0,
            1,0,0,0,0,0);
        add(0,0,1,1, 8'h03,3, 1,1,0,3, 1,1,0,4, 7,0,0, 7,0,0, 1,0,0,0,0,0);
        add(0,0,0,1, 0,0, 0,0,0,0, 0,0,0,0, 7,0,0, 7,0,0, 1,0,0,0,0,0);
        add(0,0,0,1, 0,0, 0,0,0,0, 0,0,0,0, 1,7'h12,32'hDEAD, 7,0,0,
            1,0,0,0,0,0);
        add(0,0,0,1, 0,0, 0,0,0,0, 0,0,0,0, 7,0,0, 7,0,0,
            1,1,8'h02,1,32'hDEAD,2);
        add(0,0,0,1, 0,0, 0,0,0,0, 0,0,0,0, 7,0,0, 7,0,0, 1,1,8'h03,3,4,3);
        add(0,0,0,1, 0,0, 0,0,0,0, 0,0,0,0, 7,0,0, 7,0,0, 1,0,0,0,0,0);
        add(0,0,1,1, 8'h04,4, 1,0,7'h20,0, 0,0,0,0, 2,7'h20,32'h77, 7,0,0,
            1,0,0,0,0,0);
        add(0,0,0,1, 0,0, 0,0,0,0, 0,0,0,0, 7,0,0, 7,0,0,
            1,1,8'h04,32'h77,0,4);
        add(0,0,0,1, 0,0, 0,0,0,0, 0,0,0,0, 7,0,0, 7,0,0, 1,0,0,0,0,0);
        add(0,0,1,1, 8'h05,5, 1,0,7'h30,0, 1,1,0,9, 7,0,0, 7,0,0,
            1,0,0,0,0,0);
        add(0,0,0,1, 0,0, 0,0,0,0, 0,0,0,0, 0,7'h30,1, 3,7'h30,2,
            1,0,0,0,0,0);
        add(0,0,0,1, 0,0, 0,0,0,0, 0,0,0,0, 7,0,0, 7,0,0, 1,1,8'h05,1,9,5);
        add(0,0,0,1, 0,0, 0,0,0,0, 0,0,0,0, 7,0,0, 7,0,0, 1,0,0,0,0,0);
        add(0,0,1,1, 8'h06,6, 1,0,0,0, 1,1,0,6, 0,0,32'h55, 7,0,0,
            1,0,0,0,0,0);
        add(0,0,0,1, 0,0, 0,0,0,0, 0,0,0,0, 0,0,32'h55, 4,0,32'h66,
            1,0,0,0,0,0);
        add(0,1,0,1, 0,0, 0,0,0,0, 0,0,0,0, 7,0,0, 7,0,0, 1,0,0,0,0,0);
        add(0,0,1,0, 8'h07,7, 1,1,0,32'h70, 1,1,0,32'h71, 7,0,0, 7,0,0,
            1,0,0,0,0,0);
        add(0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0, 7,0,0, 7,0,0, 1,0,0,0,0,0);
        add(0,0,0,1, 0,0, 0,0,0,0, 0,0,0,0, 7,0,0, 7,0,0,
            1,1,8'h07,32'h70,32'h71,7);
        add(0,0,0,1, 0,0, 0,0,0,0, 0,0,0,0, 7,0,0, 7,0,0, 1,0,0,0,0,0);

        phase = "table";
        foreach (tbl[i]) begin
            v = tbl[i];
            drive_disp(v.op, v.rob, v.s1a, v.s1r, v.s1t, v.s1d,
                       v.s2a, v.s2r, v.s2t, v.s2d);
            DispValid = v.dv;
            Rest = v.rst; BiqFlash = v.fl; BruReqInst = v.req;
            clr_wb();
            set_wb(v.wp0, v.wt0, v.wd0);
            set_wb(v.wp1, v.wt1, v.wd1);
            tick();
            chk($sformatf("row%0d_rdy", i), DispReady, v.xrdy);
            chk($sformatf("row%0d_out", i),
                {IqBruValid, IqBruMicOperate, IqBruSrc1Date,
                 IqBruSrc2Date, IqBruROBPtr},
                {v.xval, v.xop, v.xs1, v.xs2, v.xrob});
        end

        phase = "fill";
        do_reset();
        BruReqInst = 0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_disp(8'(32'h20 + i), 6'(8 + i), 1, 1, 0, 32'(i),
                       1, 1, 0, 32'(100 + i));
            tick();
            chk("fill_rdy", DispReady, i < DEPTH - 1);
        end
        drive_disp(8'h2F, 6'd40, 1, 1, 0, 0, 1, 1, 0, 0);
        tick();
        chk("full_rdy", DispReady, 1'b0);
        DispValid = 0;
        BruReqInst = 1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            chk("drain_op", {IqBruValid, IqBruMicOperate, IqBruROBPtr},
                {1'b1, 8'(32'h20 + i), 6'(8 + i)});
            chk("drain_rdy", DispReady, 1'b1);
        end
        tick();
        chk("drain_end", {IqBruValid, IqBruMicOperate}, 9'h0);

        phase = "flush";
        do_reset();
        BruReqInst = 0;
        for (int i = 0; i < 5; i++) begin
            drive_disp(8'(32'h40 + i), 6'(i), 1, 1, 0, 1, 1, 1, 0, 2);
            tick();
        end
        drive_disp(8'h4F, 6'd9, 1, 1, 0, 1, 1, 1, 0, 2);
        BiqFlash = 1;
        tick();
        chk("fl_rdy", DispReady, 1'b1);
        chk("fl_out", {IqBruValid, IqBruMicOperate}, 9'h0);
        idle();
        BruReqInst = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("fl_empty", {IqBruValid, IqBruMicOperate}, 9'h0);
        end

        phase = "rst_mid";
        for (int i = 0; i < 3; i++) begin
            drive_disp(8'(32'h50 + i), 6'(20 + i), 1, 1, 0, 3, 1, 1, 0, 4);
            tick();
        end
        Rest = 1;
        tick();
        chk("rst_rdy", DispReady, 1'b1);
        chk("rst_out", {IqBruValid, IqBruMicOperate}, 9'h0);
        idle();
        tick();
        chk("rst_empty", {IqBruValid, IqBruMicOperate}, 9'h0);

        phase = "random";
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            drive_rand();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
